mul8s_rr_sched: RTL and testbench

MUL8S_RR_SCHED -- requirements
Module: mul8s_rr_sched

---
 rtl/mul8s_rr_sched.sv | 126 ++++++++++++
 tb/tb_mul8s_rr_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8s_rr_sched.sv
// Round-robin arbiter that shares one external 8x8 signed multiplier between NREQ requesters.
// Products return through a credit-guarded FIFO, tagged with the requester id, in grant order.
module mul8s_rr_sched #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [8*NREQ-1:0]       req_a,
  input  logic [8*NREQ-1:0]       req_b,
  output logic [7:0]              mul_a,
  output logic [7:0]              mul_b,
  input  logic [15:0]             mul_o,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [15:0]             rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int EW  = 16 + IDW;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           s1_valid_q;
  logic [7:0]     s1_a_q, s1_b_q;
  logic [IDW-1:0] s1_id_q;

  logic [EW-1:0]  mem_q [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;

  logic           credit_ok, grant_found, accept, push, pop;
  logic [IDW-1:0] grant_idx, cand;
  logic [IDW:0]   cand_sum;
  logic [EW-1:0]  head;

  // Credit counts the stage-1 entry too, so every accepted operand pair owns a FIFO slot.
  // Only registered state feeds this, keeping rsp_ready out of the req_ready path.
  assign credit_ok = (count_q + CW'(s1_valid_q)) < CW'(DEPTH);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NREQ)) begin
        cand_sum = cand_sum - (IDW+1)'(NREQ);
      end
      cand = cand_sum[IDW-1:0];
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && credit_ok && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q  <= req_a[{grant_idx, 3'b000} +: 8];
        s1_b_q  <= req_b[{grant_idx, 3'b000} +: 8];
        s1_id_q <= grant_idx;
      end
    end
  end

  assign mul_a = s1_a_q;
  assign mul_b = s1_b_q;

  assign push      = s1_valid_q;
  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign count_d   = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: nothing is visible unless count_q says so.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {mul_o, s1_id_q};
  end

  assign head     = mem_q[rd_ptr_q];
  assign rsp_data = rsp_valid ? head[EW-1:IDW] : '0;
  assign rsp_id   = rsp_valid ? head[IDW-1:0] : '0;

endmodule

// File: tb/tb_mul8s_rr_sched.sv
// Bench for mul8s_rr_sched: directed scenarios plus random traffic, checked against a
// transaction-level model (round-robin pointer, in-flight queue, exact signed products).
module tb_mul8s_rr_sched;

  localparam int NREQ  = 4;
  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_o;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;

  mul8s_rr_sched #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
  );

  assign mul_o = $signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_b[7]}}, mul_b});

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] prod;
    int          id;
    int          acc_edge;
  } ent_t;

  ent_t        exp_q[$];
  int          glog[$];
  int          p_m;
  int          edge_n;
  int          dut_acc;
  int          vectors;
  int          miscompares;
  logic [3:0]  v;
  logic [7:0]  a_arr [4];
  logic [7:0]  b_arr [4];

  function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
    int x, y;
    x = int'($signed(a));
    y = int'($signed(b));
    return 16'(x * y);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = a_arr[i];
      req_b[8*i +: 8] = b_arr[i];
    end
    req_valid = v;
  endtask

  // One clock cycle: apply inputs, compare against the model, advance the model.
  task automatic step();
    int         g;
    int         vis;
    logic [3:0] er;
    bit         erv;
    bit         do_pop;
    drive();
    #1;
    g = -1;
    if (!reset && exp_q.size() < DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (p_m + k) % NREQ;
        if (g < 0 && v[idx] == 1'b1) g = idx;
      end
    end
    er = (g >= 0) ? 4'(1 << g) : 4'd0;
    chk("req_ready", 32'(req_ready), 32'(er));
    vis = 0;
    foreach (exp_q[i]) if (exp_q[i].acc_edge + 1 <= edge_n) vis++;
    chk("fifo_count", 32'(dut.count_q), 32'(vis));
    erv = (vis > 0);
    chk("rsp_valid", 32'(rsp_valid), 32'(erv));
    if (erv) begin
      chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].prod));
      chk("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
    end
    do_pop = erv && rsp_ready;
    if (|(req_valid & req_ready)) dut_acc++;
    @(posedge clock);
    edge_n++;
    if (do_pop) void'(exp_q.pop_front());
    if (g >= 0) begin
      exp_q.push_back('{smul(a_arr[g], b_arr[g]), g, edge_n});
      p_m = (g + 1) % NREQ;
      glog.push_back(g);
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v = 4'hF;
    drive();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    exp_q.delete();
    p_m = 0;
    @(negedge clock);
    reset = 1'b0;
    v = 4'h0;
  endtask

  task automatic drain();
    v = 4'h0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic single(input int id, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] expd);
    rsp_ready = 1'b1;
    a_arr[id] = a;
    b_arr[id] = b;
    v = 4'(1 << id);
    step();
    chk("single_mul_a", 32'(mul_a), 32'(a));
    chk("single_mul_b", 32'(mul_b), 32'(b));
    chk("single_latency_early", 32'(rsp_valid), 32'd0);
    v = 4'h0;
    step();
    chk("single_latency_valid", 32'(rsp_valid), 32'd1);
    chk("single_data", 32'(rsp_data), 32'(expd));
    chk("single_id", 32'(rsp_id), 32'(id));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    p_m = 0;
    edge_n = 0;
    dut_acc = 0;
    reset = 1'b1;
    rsp_ready = 1'b0;
    v = 4'h0;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 8'h00;
      b_arr[i] = 8'h00;
    end
    drive();
    @(negedge clock);
    do_reset();

    // Single request and boundary operands
    single(0, 8'hFD, 8'h05, 16'hFFF1);
    single(2, 8'h80, 8'h80, 16'h4000);
    single(3, 8'h7F, 8'h80, 16'hC080);
    single(1, 8'h00, 8'h4D, 16'h0000);

    // All requesters valid continuously from reset
    do_reset();
    glog.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = 8'(i * 17 + 3);
      b_arr[i] = 8'(8'hF0 - i);
    end
    v = 4'hF;
    for (int i = 0; i < 8; i++) step();
    chk("rr_count", 32'(glog.size()), 32'd8);
    for (int i = 0; i < 8 && i < glog.size(); i++) chk("rr_order", 32'(glog[i]), 32'(i % 4));
    drain();

    // Backpressure, then simultaneous push/pop while credit is exhausted
    rsp_ready = 1'b0;
    v = 4'b0010;
    dut_acc = 0;
    for (int i = 0; i < 4; i++) begin
      a_arr[1] = 8'($urandom);
      b_arr[1] = 8'($urandom);
      step();
    end
    chk("bp_accepts", 32'(dut_acc), 32'd4);
    rsp_ready = 1'b1;
    step();
    chk("pushpop_count", 32'(dut.count_q), 32'd3);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_arr[1] = 8'($urandom);
      b_arr[1] = 8'($urandom);
      step();
    end
    chk("bp_accepts_after", 32'(dut_acc), 32'd5);
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      a_arr[1] = 8'($urandom);
      b_arr[1] = 8'($urandom);
      step();
    end
    chk("bp_resume", 32'(dut_acc > 5), 32'd1);
    drain();

    // Reset with results buffered
    rsp_ready = 1'b0;
    v = 4'hF;
    for (int i = 0; i < 4; i++) step();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    v = 4'hF;
    step();
    chk("p_restart", 32'(glog[$]), 32'd0);
    drain();

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      v = 4'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        a_arr[i] = 8'($urandom);
        b_arr[i] = 8'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
